// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with a line refill FSM.
// Hits answer in the request cycle; misses refill a line, install it, then replay.
module icache_set_assoc #(
    parameter int TOTAL_SIZE_BYTES = 1024,
    parameter int NUM_WAYS         = 4,
    parameter int LINE_SIZE_BYTES  = 16,
    parameter int WORD_SIZE_BYTES  = 4,
    localparam int XLEN            = 8 * WORD_SIZE_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ifetch_icache_addr,
    input  logic            ifetch_icache_read,
    output logic [XLEN-1:0] icache_ifetch_rdata,
    output logic            icache_ifetch_resp,
    input  logic            icache_flush,
    output logic [XLEN-1:0] icache_iddr_addr,
    output logic            icache_iddr_read,
    input  logic [XLEN-1:0] iddr_icache_rdata,
    input  logic            iddr_icache_resp
);

    localparam int SETS        = TOTAL_SIZE_BYTES / (NUM_WAYS * LINE_SIZE_BYTES);
    localparam int WORDS       = LINE_SIZE_BYTES / WORD_SIZE_BYTES;
    localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int TAG_BITS    = XLEN - INDEX_BITS - OFFSET_BITS;
    localparam int BYTE_BITS   = $clog2(WORD_SIZE_BYTES);
    localparam int WSEL_BITS   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {
        LOOKUP,
        FILL,
        WRITE
    } state_t;

    typedef logic [WORDS-1:0][XLEN-1:0] line_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [NUM_WAYS-1:0][SETS-1:0] valid_q;
    logic [TAG_BITS-1:0]           tag_mem [NUM_WAYS][SETS];
    line_t                         data_mem [NUM_WAYS][SETS];
    logic [WAY_BITS-1:0]           rr_q [SETS];
    logic [WSEL_BITS-1:0]          word_cnt_q;
    logic                          flush_pending_q;
    logic [TAG_BITS-1:0]           fill_tag_q;
    logic [INDEX_BITS-1:0]         fill_idx_q;
    line_t                         line_buf_q;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [WSEL_BITS-1:0]  req_wsel;
    logic                  unused_addr_bits;

    assign req_tag          = ifetch_icache_addr[XLEN-1 -: TAG_BITS];
    assign req_idx          = ifetch_icache_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_wsel         = ifetch_icache_addr[BYTE_BITS +: WSEL_BITS];
    assign unused_addr_bits = ^ifetch_icache_addr[BYTE_BITS-1:0];

    logic [NUM_WAYS-1:0] hit_way;
    line_t               hit_line;
    logic                hit;

    // At most one way matches, so an AND-OR mux selects the hit line.
    always_comb begin
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_way[w] = valid_q[w][req_idx] &&
                         (tag_mem[w][req_idx] == req_tag);
            if (hit_way[w]) begin
                hit_line = hit_line | data_mem[w][req_idx];
            end
        end
    end

    assign hit = |hit_way;

    logic [WAY_BITS-1:0] victim;
    logic                have_invalid;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        victim       = rr_q[fill_idx_q];
        have_invalid = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][fill_idx_q]) begin
                victim       = WAY_BITS'(w);
                have_invalid = 1'b1;
            end
        end
    end

    logic in_lookup;
    logic in_fill;
    logic miss;
    logic last_word;
    logic install;

    assign in_lookup = (state_q == LOOKUP) && !rst;
    assign in_fill   = (state_q == FILL) && !rst;
    assign miss      = in_lookup && ifetch_icache_read && !hit && !icache_flush;
    assign last_word = (word_cnt_q == WSEL_BITS'(WORDS - 1));
    assign install   = (state_q == WRITE) && !rst &&
                       !flush_pending_q && !icache_flush;

    assign icache_ifetch_resp  = in_lookup && ifetch_icache_read &&
                                 hit && !icache_flush;
    assign icache_ifetch_rdata = icache_ifetch_resp ? hit_line[req_wsel] : '0;
    assign icache_iddr_read    = in_fill;
    assign icache_iddr_addr    = in_fill ?
        ({fill_tag_q, fill_idx_q, {OFFSET_BITS{1'b0}}} |
         (XLEN'(word_cnt_q) << BYTE_BITS)) : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOOKUP:  if (miss) state_d = FILL;
            FILL:    if (iddr_icache_resp && last_word) state_d = WRITE;
            WRITE:   state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOKUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            word_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            unique case (state_q)
                LOOKUP: begin
                    if (icache_flush) valid_q <= '0;
                    word_cnt_q <= '0;
                end
                FILL: begin
                    if (icache_flush) flush_pending_q <= 1'b1;
                    if (iddr_icache_resp) begin
                        word_cnt_q <= word_cnt_q + WSEL_BITS'(1);
                    end
                end
                WRITE: begin
                    flush_pending_q <= 1'b0;
                    // A flush seen during the refill drops the line entirely.
                    if (!install) begin
                        valid_q <= '0;
                    end else begin
                        valid_q[victim][fill_idx_q] <= 1'b1;
                        if (!have_invalid) begin
                            rr_q[fill_idx_q] <=
                                (rr_q[fill_idx_q] == WAY_BITS'(NUM_WAYS - 1)) ?
                                '0 : rr_q[fill_idx_q] + WAY_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (miss) begin
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
        end
        if (in_fill && iddr_icache_resp) begin
            line_buf_q[word_cnt_q] <= iddr_icache_rdata;
        end
        if (install) begin
            tag_mem[victim][fill_idx_q]  <= fill_tag_q;
            data_mem[victim][fill_idx_q] <= line_buf_q;
        end
    end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Bench for icache_set_assoc: directed vector table, flush/reset sequences,
// and random fetches against a set/way occupancy model with a memory responder.
module tb_icache_set_assoc;

    localparam int WORDS    = 4;
    localparam int LAT_MISS = 2 * WORDS + 2;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        read;
    logic [31:0] rdata;
    logic        resp;
    logic        flush;
    logic [31:0] iddr_addr;
    logic        iddr_read;
    logic [31:0] iddr_rdata;
    logic        iddr_resp;

    icache_set_assoc dut (
        .clk                 (clk),
        .rst                 (rst),
        .ifetch_icache_addr  (addr),
        .ifetch_icache_read  (read),
        .icache_ifetch_rdata (rdata),
        .icache_ifetch_resp  (resp),
        .icache_flush        (flush),
        .icache_iddr_addr    (iddr_addr),
        .icache_iddr_read    (iddr_read),
        .iddr_icache_rdata   (iddr_rdata),
        .iddr_icache_resp    (iddr_resp)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    int          wait_cnt = 0;
    logic [31:0] req_log[$];

    bit          m_valid[4][16];
    logic [23:0] m_tag[4][16];
    int          m_rr[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Instruction memory: answers each held request after mem_lat idle cycles.
    initial begin
        iddr_resp  = 1'b0;
        iddr_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            iddr_resp  = 1'b0;
            iddr_rdata = '0;
            if (!iddr_read) begin
                wait_cnt = 0;
            end else if (wait_cnt >= mem_lat) begin
                iddr_resp  = 1'b1;
                iddr_rdata = mem_word(iddr_addr);
                req_log.push_back(iddr_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int flush_at,
                         output logic ok, output logic [31:0] d,
                         output int cyc);
        ok  = 1'b0;
        d   = '0;
        cyc = -1;
        @(negedge clk);
        read = 1'b1;
        addr = a;
        for (int i = 0; i < 80; i++) begin
            flush = (i == flush_at);
            #1;
            if (resp) begin
                ok  = 1'b1;
                d   = rdata;
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    task automatic check_fill(input string name, input logic [31:0] base,
                              input int n);
        chk({name, "_nreq"}, 32'(req_log.size()), 32'(n));
        for (int k = 0; k < req_log.size() && k < n; k++) begin
            chk($sformatf("%s_req%0d", name, k), req_log[k],
                base + 32'(4 * (k % WORDS)));
        end
        req_log.delete();
    endtask

    task automatic model_clear(input bit with_rr);
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) m_valid[w][s] = 1'b0;
            if (with_rr) m_rr[s] = 0;
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int s = int'(a[7:4]);
        for (int w = 0; w < 4; w++) begin
            if (m_valid[w][s] && m_tag[w][s] == a[31:8]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int s = int'(a[7:4]);
        int v = -1;
        for (int w = 0; w < 4; w++) begin
            if (!m_valid[w][s] && v < 0) v = w;
        end
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 4;
        end
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = a[31:8];
    endtask

    initial begin
        vec_t        vecs[18];
        logic        ok;
        logic [31:0] d;
        int          cyc;
        logic [31:0] a;
        bit          exp_hit;

        vecs[0]  = '{32'h00001004, 1'b1, 32'hA1};
        vecs[1]  = '{32'h0000100C, 1'b0, 32'hA3};
        vecs[2]  = '{32'h00002000, 1'b1, mem_word(32'h2000)};
        vecs[3]  = '{32'h00003000, 1'b1, mem_word(32'h3000)};
        vecs[4]  = '{32'h00004000, 1'b1, mem_word(32'h4000)};
        vecs[5]  = '{32'h00005000, 1'b1, mem_word(32'h5000)};
        vecs[6]  = '{32'h00002000, 1'b0, mem_word(32'h2000)};
        vecs[7]  = '{32'h00001000, 1'b1, 32'hA0};
        vecs[8]  = '{32'h00003000, 1'b0, mem_word(32'h3000)};
        vecs[9]  = '{32'h00004000, 1'b0, mem_word(32'h4000)};
        vecs[10] = '{32'h00002000, 1'b1, mem_word(32'h2000)};
        vecs[11] = '{32'h00003000, 1'b1, mem_word(32'h3000)};
        vecs[12] = '{32'h00005000, 1'b0, mem_word(32'h5000)};
        vecs[13] = '{32'h00004000, 1'b1, mem_word(32'h4000)};
        vecs[14] = '{32'h00001234, 1'b1, mem_word(32'h1234)};
        vecs[15] = '{32'h00001238, 1'b0, mem_word(32'h1238)};
        vecs[16] = '{32'h80001004, 1'b1, mem_word(32'h80001004)};
        vecs[17] = '{32'h00001008, 1'b1, 32'hA2};

        rst   = 1'b1;
        read  = 1'b0;
        addr  = '0;
        flush = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_cycle_resp", 32'(resp), 32'd0);
        chk("rst_cycle_rdata", rdata, 32'd0);
        chk("rst_cycle_iddr_read", 32'(iddr_read), 32'd0);
        chk("rst_cycle_iddr_addr", iddr_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_resp", 32'(resp), 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_iddr_read", 32'(iddr_read), 32'd0);
        chk("post_rst_iddr_addr", iddr_addr, 32'd0);

        mem_lat = 1;
        req_log.delete();
        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            fetch(vecs[k].addr, -1, ok, d, cyc);
            chk({nm, "_resp"}, 32'(ok), 32'd1);
            chk({nm, "_lat"}, 32'(cyc), vecs[k].miss ? 32'(LAT_MISS) : 32'd0);
            chk({nm, "_data"}, d, vecs[k].data);
            check_fill(nm, {vecs[k].addr[31:4], 4'h0},
                       vecs[k].miss ? WORDS : 0);
        end

        fetch(32'h3000, 0, ok, d, cyc);
        chk("flush_retry_resp", 32'(ok), 32'd1);
        chk("flush_retry_lat", 32'(cyc), 32'(LAT_MISS + 1));
        chk("flush_retry_data", d, mem_word(32'h3000));
        check_fill("flush_retry", 32'h3000, WORDS);

        fetch(32'h6000, 5, ok, d, cyc);
        chk("fill_flush_resp", 32'(ok), 32'd1);
        chk("fill_flush_lat", 32'(cyc), 32'(2 * LAT_MISS));
        chk("fill_flush_data", d, mem_word(32'h6000));
        check_fill("fill_flush", 32'h6000, 2 * WORDS);
        fetch(32'h6004, -1, ok, d, cyc);
        chk("after_fill_flush_lat", 32'(cyc), 32'd0);
        chk("after_fill_flush_data", d, mem_word(32'h6004));

        fetch(32'h1000, -1, ok, d, cyc);
        chk("pre_rst_miss_lat", 32'(cyc), 32'(LAT_MISS));
        fetch(32'h1000, -1, ok, d, cyc);
        chk("pre_rst_hit_lat", 32'(cyc), 32'd0);
        req_log.delete();
        @(negedge clk);
        read = 1'b1;
        addr = 32'h7000;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_fill_iddr_read", 32'(iddr_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        read = 1'b0;
        #1;
        chk("rst_abort_iddr_read", 32'(iddr_read), 32'd0);
        chk("rst_abort_resp", 32'(resp), 32'd0);
        req_log.delete();
        fetch(32'h1000, -1, ok, d, cyc);
        chk("rst_abort_miss_resp", 32'(ok), 32'd1);
        chk("rst_abort_miss_lat", 32'(cyc), 32'(LAT_MISS));
        chk("rst_abort_miss_data", d, 32'hA0);
        check_fill("rst_abort_refill", 32'h1000, WORDS);

        @(negedge clk);
        read = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_log.delete();
        model_clear(1'b1);
        for (int it = 0; it < 200; it++) begin
            string nm;
            nm = $sformatf("rnd%0d", it);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                read  = 1'b0;
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear(1'b0);
            end
            a = (32'($urandom_range(0, 1)) << 31) |
                (32'($urandom_range(1, 6)) << 8) |
                (32'($urandom_range(0, 3)) << 4) |
                32'($urandom_range(0, 15));
            mem_lat = int'($urandom_range(0, 3));
            exp_hit = model_hit(a);
            fetch(a, -1, ok, d, cyc);
            chk({nm, "_resp"}, 32'(ok), 32'd1);
            chk({nm, "_hit"}, 32'(cyc == 0), 32'(exp_hit));
            chk({nm, "_data"}, d, mem_word({a[31:2], 2'b00}));
            check_fill(nm, {a[31:4], 4'h0}, exp_hit ? 0 : WORDS);
            if (!exp_hit) model_fill(a);
        end

        @(negedge clk);
        read = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
